// File: rtl/controlador_interseccion.sv
`default_nettype none
// ============================================================================
// Module      : controlador_interseccion
// Description : Moore FSM controller for a two-road intersection. It sequences
//               the vehicle heads SemaforoA/SemaforoB and the pedestrian walk
//               lamps Apeatonal/Bpeatonal using per-phase cycle timers and
//               latched push-button requests.
//               Optional feature macro: PEATON_PRIORIDAD_EN (a pending
//               pedestrian request cuts a green phase short once the minimum
//               green time has elapsed).
// Revision    : 1.0 - initial release
// ============================================================================
module controlador_interseccion #(
  parameter int T_GREEN     = 8,
  parameter int T_YELLOW    = 2,
  parameter int T_ALLRED    = 1,
  parameter int T_WALK      = 4,
  parameter int T_MIN_GREEN = 3,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       ENB,
  input  logic       reqPeatonA,
  input  logic       reqPeatonB,
  output logic [1:0] SemaforoA,
  output logic [1:0] SemaforoB,
  output logic       Apeatonal,
  output logic       Bpeatonal,
  output logic [2:0] fase
);

  typedef enum logic [2:0] {
    ALLRED_BA = 3'd0,
    A_GREEN   = 3'd1,
    A_YELLOW  = 3'd2,
    ALLRED_AB = 3'd3,
    B_GREEN   = 3'd4,
    B_YELLOW  = 3'd5
  } state_t;

  // Light colour codes
  localparam logic [1:0] c_red    = 2'd0;
  localparam logic [1:0] c_yellow = 2'd1;
  localparam logic [1:0] c_green  = 2'd2;

  // Terminal timer values: a phase ends on the edge where timer hits these
  localparam logic [CNT_W-1:0] c_green_last     = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] c_yellow_last    = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] c_allred_last    = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] c_min_green_last = CNT_W'(T_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] c_walk           = CNT_W'(T_WALK);

`ifdef PEATON_PRIORIDAD_EN
  localparam logic c_prio_en = 1'b1;
`else
  localparam logic c_prio_en = 1'b0;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             pendA_q, pendA_d;
  logic             pendB_q, pendB_d;
  logic             walkA_q, walkA_d;
  logic             walkB_q, walkB_d;

  logic             w_phase_done;
  logic             w_illegal;
  state_t           w_next_phase;

  // Next-state logic: phase completion, timer, request latch and walk grant
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    walkA_d      = walkA_q;
    walkB_d      = walkB_q;
    // Requests are latched every non-reset edge, even while frozen
    pendA_d      = pendA_q | reqPeatonA;
    pendB_d      = pendB_q | reqPeatonB;
    w_phase_done = 1'b0;
    w_illegal    = 1'b0;
    w_next_phase = ALLRED_BA;

    case (state_q)
      ALLRED_BA: begin
        w_phase_done = (timer_q == c_allred_last);
        w_next_phase = A_GREEN;
      end
      A_GREEN: begin
        // Early exit lets a waiting pedestrian on crossing A go sooner
        w_phase_done = (timer_q == c_green_last) ||
                       (c_prio_en && pendA_q && (timer_q >= c_min_green_last));
        w_next_phase = A_YELLOW;
      end
      A_YELLOW: begin
        w_phase_done = (timer_q == c_yellow_last);
        w_next_phase = ALLRED_AB;
      end
      ALLRED_AB: begin
        w_phase_done = (timer_q == c_allred_last);
        w_next_phase = B_GREEN;
      end
      B_GREEN: begin
        w_phase_done = (timer_q == c_green_last) ||
                       (c_prio_en && pendB_q && (timer_q >= c_min_green_last));
        w_next_phase = B_YELLOW;
      end
      B_YELLOW: begin
        w_phase_done = (timer_q == c_yellow_last);
        w_next_phase = ALLRED_BA;
      end
      default: begin
        w_illegal    = 1'b1;
        w_next_phase = ALLRED_BA;
      end
    endcase

    if (w_illegal) begin
      // Corrupted encodings recover immediately, independent of ENB
      state_d = ALLRED_BA;
      timer_d = '0;
    end else if (ENB) begin
      if (w_phase_done) begin
        state_d = w_next_phase;
        timer_d = '0;
        // Crossing A walks while road B has green, and vice versa
        if (w_next_phase == B_GREEN) begin
          walkA_d = pendA_q | reqPeatonA;
          pendA_d = 1'b0;
        end
        if (w_next_phase == A_GREEN) begin
          walkB_d = pendB_q | reqPeatonB;
          pendB_d = 1'b0;
        end
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  // State, timer and pedestrian flag registers with synchronous reset
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= ALLRED_BA;
      timer_q <= '0;
      pendA_q <= 1'b0;
      pendB_q <= 1'b0;
      walkA_q <= 1'b0;
      walkB_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pendA_q <= pendA_d;
      pendB_q <= pendB_d;
      walkA_q <= walkA_d;
      walkB_q <= walkB_d;
    end
  end

  // Moore output decode from the registered state and timer
  always_comb begin
    SemaforoA = c_red;
    SemaforoB = c_red;
    case (state_q)
      A_GREEN:  SemaforoA = c_green;
      A_YELLOW: SemaforoA = c_yellow;
      B_GREEN:  SemaforoB = c_green;
      B_YELLOW: SemaforoB = c_yellow;
      default: begin
        SemaforoA = c_red;
        SemaforoB = c_red;
      end
    endcase
    Apeatonal = (state_q == B_GREEN) && walkA_q && (timer_q < c_walk);
    Bpeatonal = (state_q == A_GREEN) && walkB_q && (timer_q < c_walk);
    fase      = state_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_controlador_interseccion.sv
`default_nettype none
// ============================================================================
// Module      : tb_controlador_interseccion
// Description : Self-checking bench for controlador_interseccion. A phase /
//               elapsed-cycle model of the intersection predicts every output
//               after each clock; directed steps cover the basic sequence,
//               pedestrian service, ENB freeze, mid-phase reset and the
//               optional early-exit feature (PEATON_PRIORIDAD_EN), followed by
//               a randomized sweep with safety invariants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controlador_interseccion;

  localparam int T_GREEN     = 8;
  localparam int T_YELLOW    = 2;
  localparam int T_ALLRED    = 1;
  localparam int T_WALK      = 4;
  localparam int T_MIN_GREEN = 3;
  localparam int CNT_W       = 8;

`ifdef PEATON_PRIORIDAD_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       RST = 1'b1;
  logic       ENB = 1'b0;
  logic       reqPeatonA = 1'b0;
  logic       reqPeatonB = 1'b0;
  logic [1:0] SemaforoA, SemaforoB;
  logic       Apeatonal, Bpeatonal;
  logic [2:0] fase;

  controlador_interseccion #(
    .T_GREEN(T_GREEN), .T_YELLOW(T_YELLOW), .T_ALLRED(T_ALLRED),
    .T_WALK(T_WALK), .T_MIN_GREEN(T_MIN_GREEN), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .RST(RST), .ENB(ENB),
    .reqPeatonA(reqPeatonA), .reqPeatonB(reqPeatonB),
    .SemaforoA(SemaforoA), .SemaforoB(SemaforoB),
    .Apeatonal(Apeatonal), .Bpeatonal(Bpeatonal), .fase(fase)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model: phase index in cycle order, cycles spent in the phase,
  // pending pedestrian requests and the walk grant of the current cycle.
  int dur [6];
  int m_ph = 0;
  int m_el = 0;
  bit m_pA = 0, m_pB = 0, m_wA = 0, m_wB = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input bit ra, input bit rb);
    bit nA, nB, done;
    int nxt;
    if (r) begin
      m_ph = 0; m_el = 0;
      m_pA = 0; m_pB = 0; m_wA = 0; m_wB = 0;
      return;
    end
    nA = m_pA | ra;
    nB = m_pB | rb;
    if (e) begin
      done = (m_el + 1 >= dur[m_ph]);
      if (PRIO && m_ph == 1 && m_pA && (m_el + 1 >= T_MIN_GREEN)) done = 1;
      if (PRIO && m_ph == 4 && m_pB && (m_el + 1 >= T_MIN_GREEN)) done = 1;
      if (done) begin
        nxt  = (m_ph + 1) % 6;
        m_el = 0;
        if (nxt == 4) begin m_wA = m_pA | ra; nA = 0; end
        if (nxt == 1) begin m_wB = m_pB | rb; nB = 0; end
        m_ph = nxt;
      end else begin
        m_el++;
      end
    end
    m_pA = nA;
    m_pB = nB;
  endtask

  task automatic check_all();
    int ea, eb;
    bit eap, ebp, safe;
    ea  = (m_ph == 1) ? 2 : (m_ph == 2) ? 1 : 0;
    eb  = (m_ph == 4) ? 2 : (m_ph == 5) ? 1 : 0;
    eap = (m_ph == 4) && m_wA && (m_el < T_WALK);
    ebp = (m_ph == 1) && m_wB && (m_el < T_WALK);
    check("fase", fase, m_ph[7:0]);
    check("SemaforoA", SemaforoA, ea[7:0]);
    check("SemaforoB", SemaforoB, eb[7:0]);
    check("Apeatonal", Apeatonal, eap);
    check("Bpeatonal", Bpeatonal, ebp);
    safe = !(SemaforoA != 2'd0 && SemaforoB != 2'd0) &&
           (SemaforoA != 2'd3) && (SemaforoB != 2'd3) &&
           (!Apeatonal || (SemaforoA == 2'd0 && SemaforoB == 2'd2)) &&
           (!Bpeatonal || (SemaforoA == 2'd2 && SemaforoB == 2'd0));
    check("safety", safe, 1'b1);
  endtask

  task automatic tick(input bit r, input bit e, input bit ra, input bit rb);
    RST = r; ENB = e; reqPeatonA = ra; reqPeatonB = rb;
    @(posedge clk);
    model_step(r, e, ra, rb);
    #1;
    check_all();
  endtask

  task automatic run_until(input logic [2:0] ph, input int limit);
    int n;
    n = 0;
    while (fase !== ph && n < limit) begin
      tick(0, 1, 0, 0);
      n++;
    end
    check("reach_phase", fase, {5'd0, ph});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt, guard, green_len;
    logic [1:0] hold_a;
    dur = '{T_ALLRED, T_GREEN, T_YELLOW, T_ALLRED, T_GREEN, T_YELLOW};

    // Reset and a full undisturbed cycle
    tick(1, 0, 0, 0);
    tick(1, 1, 0, 0);
    check("rst_fase", fase, 8'd0);
    check("rst_semA", SemaforoA, 8'd0);
    check("rst_semB", SemaforoB, 8'd0);
    check("rst_walk", {Apeatonal, Bpeatonal}, 8'd0);
    tick(0, 1, 0, 0);
    check("seq_a_green", fase, 8'd1);
    check("seq_a_green_code", SemaforoA, 8'd2);
    repeat (T_GREEN) tick(0, 1, 0, 0);
    check("seq_a_yellow", fase, 8'd2);
    repeat (T_YELLOW + T_ALLRED) tick(0, 1, 0, 0);
    check("seq_b_green", fase, 8'd4);
    check("seq_b_green_code", SemaforoB, 8'd2);
    repeat (T_GREEN + T_YELLOW) tick(0, 1, 0, 0);
    check("seq_wrap", fase, 8'd0);

    // Pedestrian A: one-cycle pulse during A green, served in next B green
    tick(0, 1, 0, 0);
    tick(0, 1, 1, 0);
    run_until(3'd4, 40);
    cnt = 0; guard = 0;
    while (fase === 3'd4 && guard < 50) begin
      cnt += int'(Apeatonal);
      tick(0, 1, 0, 0);
      guard++;
    end
    check("walkA_cycles", cnt[7:0], T_WALK[7:0]);
    run_until(3'd4, 40);
    cnt = 0; guard = 0;
    while (fase === 3'd4 && guard < 50) begin
      cnt += int'(Apeatonal);
      tick(0, 1, 0, 0);
      guard++;
    end
    check("walkA_not_repeated", cnt[7:0], 8'd0);

    // ENB freeze in A green at timer 3
    tick(1, 1, 0, 0);
    tick(0, 1, 0, 0);
    repeat (3) tick(0, 1, 0, 0);
    hold_a = SemaforoA;
    repeat (5) tick(0, 0, 0, 0);
    check("freeze_fase", fase, 8'd1);
    check("freeze_semA", SemaforoA, {6'd0, hold_a});
    repeat (4) tick(0, 1, 0, 0);
    check("freeze_resume_green", fase, 8'd1);
    tick(0, 1, 0, 0);
    check("freeze_resume_yellow", fase, 8'd2);

    // Reset in the middle of a walk, with requests pending
    tick(1, 1, 0, 0);
    tick(0, 1, 0, 0);
    tick(0, 1, 1, 0);
    run_until(3'd4, 40);
    check("walk_before_reset", Apeatonal, 8'd1);
    tick(0, 1, 1, 1);
    tick(1, 1, 0, 0);
    check("midrst_fase", fase, 8'd0);
    check("midrst_outs", {SemaforoA, SemaforoB, Apeatonal, Bpeatonal}, 8'd0);
    run_until(3'd1, 10);
    check("midrst_no_walkB", Bpeatonal, 8'd0);
    run_until(3'd4, 40);
    check("midrst_no_walkA", Apeatonal, 8'd0);

    // Early pedestrian exit from A green (or full green without the feature)
    tick(1, 1, 0, 0);
    tick(0, 1, 0, 0);
    tick(0, 1, 1, 0);
    green_len = 1;
    while (fase === 3'd1 && green_len < 40) begin
      tick(0, 1, 0, 0);
      green_len++;
    end
    check("green_len", green_len[7:0], PRIO ? T_MIN_GREEN[7:0] : T_GREEN[7:0]);

    // Randomized sweep against the model and the safety invariants
    tick(1, 1, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      tick($urandom_range(0, 199) == 0,
           $urandom_range(0, 9) != 0,
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 15) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/controlador_interseccion.md
Name: controlador_interseccion

Overview:
- Moore FSM controller that sequences a two-road intersection: vehicle heads SemaforoA/SemaforoB and pedestrian walk lamps Apeatonal/Bpeatonal.
- Generates the colour codes that feed the semaforo light block, using per-phase cycle timers and latched pedestrian push-button requests.
- Sits between the push-button/enable inputs and the semaforo output stage.

Parameters:
- T_GREEN, 8: cycles per green phase (>=1).
- T_YELLOW, 2: cycles per yellow phase (>=1).
- T_ALLRED, 1: all-red clearance cycles between roads (>=1).
- T_WALK, 4: walk-lamp cycles at the start of a green phase (1..T_GREEN).
- T_MIN_GREEN, 3: minimum green before pedestrian early exit; only used with the optional feature (1..T_GREEN).
- CNT_W, 8: phase-timer width; must hold max(T_*)-1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- RST  input  1  reset, synchronous, active-high.
- ENB  input  1  enable; 0 freezes FSM and timer.
- reqPeatonA  input  1  pedestrian button, crossing over road A.
- reqPeatonB  input  1  pedestrian button, crossing over road B.
- SemaforoA  output  2  road A head: 0 red, 1 yellow, 2 green (3 never driven).
- SemaforoB  output  2  road B head, same encoding.
- Apeatonal  output  1  walk lamp, crossing A.
- Bpeatonal  output  1  walk lamp, crossing B.
- fase  output  3  current state encoding (debug).

Behaviour:
- Clocking and reset: one clock, clk. Reset RST is synchronous and active-high. While RST=1 at an edge: fase=ALLRED_BA, timer=0, pendA=pendB=0, walkA=walkB=0, SemaforoA=0, SemaforoB=0, Apeatonal=0, Bpeatonal=0. RST has priority over ENB and requests; it aborts any phase mid-operation.
- States and encodings: ALLRED_BA=0, A_GREEN=1, A_YELLOW=2, ALLRED_AB=3, B_GREEN=4, B_YELLOW=5. Encodings 6-7 are illegal and recover to ALLRED_BA at the next edge.
- Cycle order: ALLRED_BA -> A_GREEN -> A_YELLOW -> ALLRED_AB -> B_GREEN -> B_YELLOW -> ALLRED_BA.
- Phase durations: each state lasts exactly its T_* enabled cycles. Transition on the edge where timer==T_x-1; the timer clears to 0 on every transition and otherwise increments.
- With defaults the period is 22 enabled cycles; after RST release: 1 cycle all-red, then A green for 8 cycles.
- Output decode (registered with fase, Moore):
  - A_GREEN: A=2, B=0.
  - A_YELLOW: A=1, B=0.
  - B_GREEN: A=0, B=2.
  - B_YELLOW: A=0, B=1.
  - ALLRED_*: A=0, B=0.
  - A and B are never simultaneously non-red.
- ENB=0: state, timer and walk flags hold; outputs hold their current values. Pedestrian requests are still latched.
- Request latch: pendA is set on any non-reset edge where reqPeatonA=1; pendB likewise.
- Serving crossing A (during B_GREEN):
  - On the edge entering B_GREEN, walkA <= pendA|reqPeatonA and pendA <= 0.
  - Apeatonal=1 while fase==B_GREEN, walkA=1 and timer<T_WALK.
  - A request arriving after entry sets pendA for the next cycle's service.
- Serving crossing B: symmetric, on the edge entering A_GREEN, driving Bpeatonal.
- A walk lamp is never 1 outside its green state. Button held continuously: served once per cycle, re-latched immediately after.

Optional Feature:
- Macro: PEATON_PRIORIDAD_EN.
- Defined: in A_GREEN, if pendA=1 and timer>=T_MIN_GREEN-1, go to A_YELLOW on that edge. B_GREEN is symmetric with pendB. The yellow and all-red durations are unchanged.
- Undefined: green always lasts T_GREEN and T_MIN_GREEN is ignored.

Test Plan:
1. Reset/sequence: RST=1 for 2 edges, then RST=0, ENB=1, no requests -> fase 0 (1 cyc), 1 (8), 2 (2), 3 (1), 4 (8), 5 (2), 0; Semaforo codes match the decode table; walk lamps stay 0.
2. Pedestrian A: pulse reqPeatonA for 1 cycle during A_GREEN -> Apeatonal=1 for the first 4 cycles of the following B_GREEN, then 0; pendA=0 afterwards; next B_GREEN shows no walk.
3. ENB freeze: drop ENB for 5 cycles at A_GREEN timer=3 -> outputs and fase hold; after ENB=1, A_GREEN continues for 4 more cycles (8 enabled total).
4. Reset mid-phase: assert RST during B_GREEN with Apeatonal=1 -> next edge all outputs 0, fase=0, pending requests lost.
5. Safety sweep: random ENB/request stimulus for 2000 cycles -> never (SemaforoA!=0 && SemaforoB!=0); never code 3; Apeatonal only while SemaforoA=0 and SemaforoB=2.
6. PEATON_PRIORIDAD_EN defined: reqPeatonA at A_GREEN timer=0 -> A_YELLOW entered after 3 green cycles; macro undefined -> after 8.
